// File: rtl/clk_rst_seq_if.sv
// Control/status bundle of the clock/reset sequencer.
// The master side issues start/stop requests and reports PLL lock status;
// the slave side is the sequencer itself.
interface clk_rst_seq_if;
  logic       start_i;
  logic       stop_i;
  logic [2:0] pll_locked_i;
  logic [4:0] clk_en_o;
  logic [4:0] arst_n_o;
  logic       busy_o;
  logic       up_o;
  logic       err_o;
  logic [2:0] state_o;

  modport master (
    output start_i, stop_i, pll_locked_i,
    input  clk_en_o, arst_n_o, busy_o, up_o, err_o, state_o
  );

  modport slave (
    input  start_i, stop_i, pll_locked_i,
    output clk_en_o, arst_n_o, busy_o, up_o, err_o, state_o
  );
endinterface

// File: rtl/clk_rst_seq.sv
// Clock/reset sequencer: waits for all PLLs to lock, enables the domain
// clocks one by one (e_core first, pl last), then releases the domain
// resets in reverse order (pl first, e_core last). Lock loss drops every
// domain immediately and raises a sticky error; stop_i performs an orderly
// shutdown (resets first, clocks STAGE_DLY cycles later).
module clk_rst_seq #(
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STAGE_DLY    = 16
) (
  input  logic       ref_clk_i,
  input  logic       glob_arst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [2:0] pll_locked_i,
  output logic [4:0] clk_en_o,
  output logic [4:0] arst_n_o,
  output logic       busy_o,
  output logic       up_o,
  output logic       err_o,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_CLK_ON    = 3'd2,
    S_RST_REL   = 3'd3,
    S_UP        = 3'd4,
    S_SHUT      = 3'd5,
    S_ERR       = 3'd6
  } state_e;

  localparam int MAX_DLY = (LOCK_TIMEOUT > STAGE_DLY) ? LOCK_TIMEOUT : STAGE_DLY;
  localparam int CNT_W   = $clog2(MAX_DLY) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [2:0]       stage_q,  stage_d;
  logic [4:0]       clk_en_q, clk_en_d;
  logic [4:0]       arst_n_q, arst_n_d;
  logic             busy_q,   busy_d;
  logic             up_q,     up_d;
  logic             err_q,    err_d;

  logic lock_ok;
  logic stage_done;

  assign lock_ok    = &pll_locked_i;
  assign stage_done = (cnt_q == STAGE_LAST);

  // Next-state, counter, stage index and output computation.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    stage_d  = stage_q;
    clk_en_d = clk_en_q;
    arst_n_d = arst_n_q;
    err_d    = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
          stage_d = 3'd0;
          err_d   = 1'b0;
        end
      end

      S_WAIT_LOCK: begin
        if (stop_i) begin
          state_d  = S_SHUT;
          cnt_d    = '0;
          arst_n_d = 5'b00000;
        end else if (lock_ok) begin
          state_d  = S_CLK_ON;
          cnt_d    = '0;
          stage_d  = 3'd0;
          clk_en_d = 5'b00001;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = S_ERR;
          cnt_d   = '0;
          err_d   = 1'b1;
        end
      end

      S_CLK_ON, S_RST_REL, S_UP: begin
        if (!lock_ok) begin
          state_d  = S_ERR;
          cnt_d    = '0;
          stage_d  = 3'd0;
          clk_en_d = 5'b00000;
          arst_n_d = 5'b00000;
          err_d    = 1'b1;
        end else if (stop_i) begin
          state_d  = S_SHUT;
          cnt_d    = '0;
          stage_d  = 3'd0;
          arst_n_d = 5'b00000;
        end else if (state_q == S_CLK_ON && stage_done) begin
          cnt_d = '0;
          if (stage_q == 3'd4) begin
            // All clocks running: start releasing resets from the pl domain.
            state_d  = S_RST_REL;
            arst_n_d = 5'b10000;
          end else begin
            stage_d  = stage_q + 3'd1;
            clk_en_d = clk_en_q | (5'b00001 << stage_d);
          end
        end else if (state_q == S_RST_REL && stage_done) begin
          // stage_q holds the index of the last released reset (4..1).
          cnt_d    = '0;
          stage_d  = stage_q - 3'd1;
          arst_n_d = arst_n_q | (5'b00001 << stage_d);
          if (stage_q == 3'd1) begin
            state_d = S_UP;
          end
        end
      end

      S_SHUT: begin
        if (stage_done) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          clk_en_d = 5'b00000;
        end
      end

      S_ERR: begin
        clk_en_d = 5'b00000;
        arst_n_d = 5'b00000;
        if (stop_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d  = S_IDLE;
        cnt_d    = '0;
        stage_d  = 3'd0;
        clk_en_d = 5'b00000;
        arst_n_d = 5'b00000;
      end
    endcase

    busy_d = (state_d == S_WAIT_LOCK) || (state_d == S_CLK_ON) ||
             (state_d == S_RST_REL)   || (state_d == S_SHUT);
    up_d   = (state_d == S_UP);
  end

  // State, counter and registered outputs; everything clears on reset.
  always_ff @(posedge ref_clk_i or negedge glob_arst_ni) begin
    if (!glob_arst_ni) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      stage_q  <= 3'd0;
      clk_en_q <= 5'b00000;
      arst_n_q <= 5'b00000;
      busy_q   <= 1'b0;
      up_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // computed from the previous cycle, independent of statement order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stage_q  <= stage_d;
      clk_en_q <= clk_en_d;
      arst_n_q <= arst_n_d;
      busy_q   <= busy_d;
      up_q     <= up_d;
      err_q    <= err_d;
    end
  end

  assign clk_en_o = clk_en_q;
  assign arst_n_o = arst_n_q;
  assign busy_o   = busy_q;
  assign up_o     = up_q;
  assign err_o    = err_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Self-checking bench for clk_rst_seq with default parameters.
// Expected output snapshots are queued with the cycle at which they are due
// and compared one time unit after that rising edge.
module tb_clk_rst_seq;
  localparam int LOCK_TIMEOUT = 4096;
  localparam int STAGE_DLY    = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  clk_rst_seq_if bus ();

  clk_rst_seq #(
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .STAGE_DLY   (STAGE_DLY)
  ) dut (
    .ref_clk_i   (clk),
    .glob_arst_ni(rst_n),
    .start_i     (bus.start_i),
    .stop_i      (bus.stop_i),
    .pll_locked_i(bus.pll_locked_i),
    .clk_en_o    (bus.clk_en_o),
    .arst_n_o    (bus.arst_n_o),
    .busy_o      (bus.busy_o),
    .up_o        (bus.up_o),
    .err_o       (bus.err_o),
    .state_o     (bus.state_o)
  );

  // Bring-up vector: expected outputs at a cycle offset from the edge that
  // sets clk_en_o[0].
  typedef struct {
    int         off;
    logic [4:0] clk_en;
    logic [4:0] arst_n;
    logic [2:0] state;
    logic       busy;
    logic       up;
    logic       err;
  } vec_t;

  typedef struct {
    string       name;
    int          at;
    logic [15:0] exp;
  } sb_t;

  vec_t tbl [14];
  sb_t  sb_q[$];

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pack(logic [4:0] ce, logic [4:0] ar, logic [2:0] st,
                                       logic b, logic u, logic e);
    return {ce, ar, st, b, u, e};
  endfunction

  function automatic logic [15:0] observed();
    return pack(bus.clk_en_o, bus.arst_n_o, bus.state_o, bus.busy_o, bus.up_o, bus.err_o);
  endfunction

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s @cyc %0d: got clk_en=%b arst_n=%b state=%0d busy=%b up=%b err=%b, required clk_en=%b arst_n=%b state=%0d busy=%b up=%b err=%b",
               name, cyc, got[15:11], got[10:6], got[5:3], got[2], got[1], got[0],
               exp[15:11], exp[10:6], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic expect_at(string name, int at, logic [4:0] ce, logic [4:0] ar,
                           logic [2:0] st, logic b, logic u, logic e);
    sb_t item;
    item.name = name;
    item.at   = at;
    item.exp  = pack(ce, ar, st, b, u, e);
    sb_q.push_back(item);
  endtask

  // Advance to the falling edge at which cyc == target.
  task automatic step_to(int target);
    while (cyc < target) @(negedge clk);
  endtask

  // From IDLE: request bring-up with all PLLs locked. t0 is the edge that
  // sets clk_en_o[0] (IDLE->WAIT_LOCK on the next edge, ->CLK_ON one later).
  task automatic bringup(int limit, output int t0);
    bus.stop_i       = 1'b0;
    bus.pll_locked_i = 3'b111;
    bus.start_i      = 1'b1;
    t0 = cyc + 2;
    expect_at("bu_wait_lock", t0 - 1, 5'b00000, 5'b00000, 3'd1, 1'b1, 1'b0, 1'b0);
    foreach (tbl[i]) begin
      if (tbl[i].off <= limit)
        expect_at($sformatf("bu_off%0d", tbl[i].off), t0 + tbl[i].off, tbl[i].clk_en,
                  tbl[i].arst_n, tbl[i].state, tbl[i].busy, tbl[i].up, tbl[i].err);
    end
    step_to(t0 + limit);
  endtask

  // Scoreboard consumer: compare every snapshot that falls due at this edge.
  initial begin : checker_proc
    sb_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
        e = sb_q.pop_front();
        if (e.at < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s: due at cyc %0d, not compared until cyc %0d", e.name, e.at, cyc);
        end else begin
          check(e.name, observed(), e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t0;
    int n;

    tbl[0]  = '{0,   5'b00001, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{15,  5'b00001, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{16,  5'b00011, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{32,  5'b00111, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{48,  5'b01111, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{64,  5'b11111, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{79,  5'b11111, 5'b00000, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{80,  5'b11111, 5'b10000, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{96,  5'b11111, 5'b11000, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{112, 5'b11111, 5'b11100, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{128, 5'b11111, 5'b11110, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{143, 5'b11111, 5'b11110, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{144, 5'b11111, 5'b11111, 3'd4, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{150, 5'b11111, 5'b11111, 3'd4, 1'b0, 1'b1, 1'b0};

    bus.start_i      = 1'b0;
    bus.stop_i       = 1'b0;
    bus.pll_locked_i = 3'b000;
    rst_n            = 1'b0;

    // Reset values while reset is held, then IDLE after release.
    step_to(2);
    expect_at("rst_hold", cyc + 1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step_to(4);
    rst_n = 1'b1;
    expect_at("rst_rel_idle", cyc + 2, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step_to(cyc + 3);

    // start and stop together in IDLE: stay in IDLE.
    bus.start_i      = 1'b1;
    bus.stop_i       = 1'b1;
    bus.pll_locked_i = 3'b111;
    n = cyc;
    expect_at("idle_start_stop_a", n + 1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    expect_at("idle_start_stop_b", n + 3, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step_to(n + 4);

    // Full bring-up to UP.
    bringup(150, t0);

    // Lock loss in UP.
    bus.pll_locked_i = 3'b101;
    n = cyc;
    expect_at("lockloss_up", n + 1, 5'b00000, 5'b00000, 3'd6, 1'b0, 1'b0, 1'b1);
    step_to(n + 1);
    bus.pll_locked_i = 3'b111;
    expect_at("err_hold", n + 3, 5'b00000, 5'b00000, 3'd6, 1'b0, 1'b0, 1'b1);
    step_to(n + 3);

    // stop_i leaves ERR for IDLE with err_o still set; start held too.
    bus.stop_i = 1'b1;
    n = cyc;
    expect_at("err_stop_idle", n + 1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1);
    expect_at("err_sticky_idle", n + 2, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1);
    step_to(n + 2);

    // Second bring-up: err_o clears on leaving IDLE.
    bringup(150, t0);

    // Orderly stop from UP, start still high.
    bus.stop_i = 1'b1;
    n = cyc;
    expect_at("stop_up",   n + 1,  5'b11111, 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0);
    expect_at("shut_hold", n + 16, 5'b11111, 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0);
    expect_at("shut_done", n + 17, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    expect_at("shut_idle", n + 18, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step_to(n + 18);

    // stop and lock loss on the same edge in RST_REL: lock loss wins.
    bringup(90, t0);
    bus.stop_i       = 1'b1;
    bus.pll_locked_i = 3'b101;
    n = cyc;
    expect_at("rstrel_stop_lockloss", n + 1, 5'b00000, 5'b00000, 3'd6, 1'b0, 1'b0, 1'b1);
    step_to(n + 1);
    bus.pll_locked_i = 3'b111;
    expect_at("rstrel_err_to_idle", n + 2, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1);
    step_to(n + 2);
    bus.stop_i  = 1'b0;
    bus.start_i = 1'b0;
    step_to(cyc + 2);

    // Lock timeout: one PLL never locks.
    bus.pll_locked_i = 3'b011;
    bus.start_i      = 1'b1;
    n = cyc + 1;  // edge that enters WAIT_LOCK
    expect_at("to_enter",   n,                    5'b00000, 5'b00000, 3'd1, 1'b1, 1'b0, 1'b0);
    expect_at("to_last",    n + LOCK_TIMEOUT - 1, 5'b00000, 5'b00000, 3'd1, 1'b1, 1'b0, 1'b0);
    expect_at("to_err",     n + LOCK_TIMEOUT,     5'b00000, 5'b00000, 3'd6, 1'b0, 1'b0, 1'b1);
    step_to(n + LOCK_TIMEOUT);
    bus.start_i      = 1'b0;
    bus.stop_i       = 1'b1;
    bus.pll_locked_i = 3'b111;
    expect_at("to_stop_idle", cyc + 1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b1);
    step_to(cyc + 1);
    bus.stop_i = 1'b0;
    step_to(cyc + 2);

    // Asynchronous reset in CLK_ON with clk_en_o = 5'b00111.
    bringup(40, t0);
    rst_n = 1'b0;
    #1;
    check("async_rst_mid_seq", observed(), pack(5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0));
    bus.start_i = 1'b0;
    step_to(cyc + 2);
    rst_n = 1'b1;
    n = cyc;
    expect_at("post_rst_idle_a", n + 1, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    expect_at("post_rst_idle_b", n + 5, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, 1'b0);
    step_to(n + 6);
    @(posedge clk);
    #2;

    while (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s: never compared (due at cyc %0d)", sb_q[0].name, sb_q[0].at);
      void'(sb_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
CLK_RST_SEQ -- requirements
Module: clk_rst_seq

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 4096: cycles allowed in WAIT_LOCK for all PLLs to lock.
REQ-002 Parameter STAGE_DLY, default 16: cycles between successive clock-enable and reset-release steps; legal range is 1 to 65535.
REQ-003 The block SHALL have one clock, ref_clk_i; reset SHALL be glob_arst_ni, asynchronous and active-low.
REQ-004 Ports (name  direction  width  meaning):
- ref_clk_i  in  1  reference clock; all logic runs on it.
- glob_arst_ni  in  1  global asynchronous reset, active-low.
- start_i  in  1  level request to bring all domains up.
- stop_i  in  1  level request for orderly shutdown, or to clear an error.
- pll_locked_i  in  3  lock status, bit order {sl, p_core, e_core}.
- clk_en_o  out  5  domain clock enables, bit order {pl, sl, cl, p_core, e_core}.
- arst_n_o  out  5  domain resets, active-low, same bit order; drive the clock/reset generator's arst_*_ni.
- busy_o  out  1  sequencing in progress.
- up_o  out  1  all domains enabled and out of reset.
- err_o  out  1  sticky flag for lock timeout or lock loss.
- state_o  out  3  current FSM state encoding.

Function
REQ-005 FSM encodings: IDLE=0, WAIT_LOCK=1, CLK_ON=2, RST_REL=3, UP=4, SHUT=5, ERR=6; state_o SHALL show the registered state.
REQ-006 All outputs SHALL be registered.
- busy_o=1 exactly in states WAIT_LOCK, CLK_ON, RST_REL and SHUT.
- up_o=1 exactly in state UP.
REQ-007 IDLE: start_i=1 and stop_i=0 SHALL move to WAIT_LOCK, clear the cycle counter and clear err_o.
REQ-008 WAIT_LOCK:
- When pll_locked_i==3'b111, the next edge SHALL enter CLK_ON and set clk_en_o[0].
- Otherwise, when the counter reaches LOCK_TIMEOUT-1, the next edge SHALL enter ERR.
REQ-009 CLK_ON: clk_en_o[k] SHALL set STAGE_DLY cycles after clk_en_o[k-1], for k=1..4; enables set SHALL stay set.
REQ-010 STAGE_DLY cycles after clk_en_o[4] sets, the block SHALL enter RST_REL and deassert arst_n_o[4] (set it to 1).
REQ-011 RST_REL: arst_n_o[k] SHALL deassert STAGE_DLY cycles after arst_n_o[k+1], for k=3..0. The edge that deasserts arst_n_o[0] SHALL also enter UP.
REQ-012 Lock loss: any pll_locked_i bit at 0 while in CLK_ON, RST_REL or UP SHALL cause, on the next edge:
- entry to ERR;
- arst_n_o=5'b00000;
- clk_en_o=5'b00000;
- err_o=1.
REQ-013 Stop request: stop_i=1 in WAIT_LOCK, CLK_ON, RST_REL or UP SHALL cause, on the next edge, entry to SHUT with arst_n_o=5'b00000.
- After STAGE_DLY cycles in SHUT: clk_en_o=5'b00000 and the state returns to IDLE.
REQ-014 Priority on the same edge: lock loss SHALL beat stop_i, and stop_i SHALL beat start_i and stage progress.
REQ-015 start_i deasserting after the sequence has begun SHALL have no effect; only stop_i shuts down.
REQ-016 ERR: outputs SHALL hold at arst_n_o=0 and clk_en_o=0. stop_i=1 SHALL return to IDLE with err_o still 1; err_o clears only per REQ-007.
REQ-017 Counter:
- Width is clog2(max(LOCK_TIMEOUT, STAGE_DLY))+1 bits.
- It clears on every state change and every stage step.
- It SHALL never wrap.
REQ-018 Stage index: 3 bits, values 0..4; it SHALL not advance past 4.

Reset
REQ-019 While glob_arst_ni=0, asynchronously:
- state=IDLE;
- clk_en_o=5'b00000;
- arst_n_o=5'b00000;
- busy_o=0, up_o=0, err_o=0;
- counter=0, stage index=0.
REQ-020 If reset asserts mid-sequence, every output SHALL return at once to its reset value, and no sequence SHALL resume after reset releases.

Verification
REQ-021 Bring-up: defaults, start_i=1, locks=3'b111; clk_en_o[0] sets at T.
- Required: clk_en_o=5'b11111 at T+64.
- Required: arst_n_o[4]=1 at T+80, arst_n_o[0]=1 at T+144.
- Required: up_o=1 at T+144.
REQ-022 Timeout: start_i=1 with locks=3'b011. Required: ERR, err_o=1 and busy_o=0 exactly 4096 cycles after WAIT_LOCK is entered.
REQ-023 Lock loss in UP: drop pll_locked_i[1]. Required on the next edge: clk_en_o=0, arst_n_o=0, state_o=6, up_o=0.
REQ-024 Stop in UP: stop_i=1. Required on the next edge: arst_n_o=0.
- Required 16 cycles later: clk_en_o=0 and state_o=0.
REQ-025 Simultaneous events: stop_i and lock loss on the same cycle in RST_REL -> ERR; start_i and stop_i together in IDLE -> stays in IDLE.
REQ-026 Reset mid-sequence: assert glob_arst_ni=0 during CLK_ON with clk_en_o=5'b00111. Required: all outputs 0 immediately, and state_o=0 after reset releases.
